// File: rtl/udp_encode8.sv
// UDP header serialiser: latches the header fields on an accepted start and sends
// the 8 header bytes big-endian on an 8-bit valid/ready stream.
module udp_encode8 #(
    parameter int AVL_SIZE      = 8,
    parameter int BYTE_SIZE     = 8,
    parameter int HDR_BYTES     = 8,
    parameter int ZERO_CHECKSUM = 0
) (
    input  logic                clk,
    input  logic                sync_reset,
    input  logic                start,
    input  logic [15:0]         src_port,
    input  logic [15:0]         dst_port,
    input  logic [15:0]         payload_length,
    input  logic [15:0]         checksum,
    output logic                busy,
    output logic [AVL_SIZE-1:0] data_out,
    output logic                data_out_valid,
    input  logic                data_out_ready,
    output logic                data_out_sop,
    output logic                data_out_eop,
    output logic                hdr_done,
    output logic                length_error
);

    localparam int CNT_W = $clog2(HDR_BYTES);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t               state, state_nx;
    logic [CNT_W-1:0]     byte_cnt, byte_cnt_nx;
    logic [15:0]          src_q, dst_q, len_q, cks_q;
    logic [16:0]          len17;
    logic                 accept;
    logic                 fire;
    logic                 last_byte;
    logic [BYTE_SIZE-1:0] hdr_byte [HDR_BYTES];

    assign len17 = {1'b0, payload_length} + 17'd8;

    always_ff @(posedge clk) begin
        if (sync_reset) begin
            state    <= IDLE;
            byte_cnt <= '0;
        end else begin
            state    <= state_nx;
            byte_cnt <= byte_cnt_nx;
        end
    end

    always_comb begin
        state_nx       = state;
        byte_cnt_nx    = byte_cnt;
        accept         = 1'b0;
        fire           = 1'b0;
        last_byte      = (byte_cnt == CNT_W'(HDR_BYTES - 1));
        busy           = 1'b0;
        data_out_valid = 1'b0;
        data_out_sop   = 1'b0;
        data_out_eop   = 1'b0;
        data_out       = '0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept      = 1'b1;
                    state_nx    = SEND;
                    byte_cnt_nx = '0;
                end
            end
            SEND: begin
                busy           = 1'b1;
                data_out_valid = 1'b1;
                data_out       = hdr_byte[byte_cnt];
                data_out_sop   = (byte_cnt == '0);
                data_out_eop   = last_byte;
                fire           = data_out_ready;
                if (fire) begin
                    if (last_byte) begin
                        state_nx    = IDLE;
                        byte_cnt_nx = '0;
                    end else begin
                        byte_cnt_nx = byte_cnt + 1'b1;
                    end
                end
            end
            default: begin
                state_nx    = IDLE;
                byte_cnt_nx = '0;
            end
        endcase
    end

    always_comb begin
        hdr_byte[0] = src_q[15:8];
        hdr_byte[1] = src_q[7:0];
        hdr_byte[2] = dst_q[15:8];
        hdr_byte[3] = dst_q[7:0];
        hdr_byte[4] = len_q[15:8];
        hdr_byte[5] = len_q[7:0];
        hdr_byte[6] = cks_q[15:8];
        hdr_byte[7] = cks_q[7:0];
    end

    // Fields are captured only on the accepted start, so input changes mid-header are invisible.
    always_ff @(posedge clk) begin
        if (sync_reset) begin
            src_q <= '0;
            dst_q <= '0;
            len_q <= '0;
            cks_q <= '0;
        end else if (accept) begin
            src_q <= src_port;
            dst_q <= dst_port;
            len_q <= len17[16] ? 16'hFFFF : len17[15:0];
            cks_q <= (ZERO_CHECKSUM != 0) ? 16'h0000 : checksum;
        end
    end

    always_ff @(posedge clk) begin
        if (sync_reset) begin
            hdr_done     <= 1'b0;
            length_error <= 1'b0;
        end else begin
            hdr_done     <= fire && last_byte;
            length_error <= accept && len17[16];
        end
    end

endmodule
